mesm6_timer: RTL and testbench
==============================

// Module: mesm6_timer
// PURPOSE
// Interval timer responder on the mesm6 data bus: the target end of the CPU's
// rd/wr/addr/done handshake, reached through mesm6_mmu like mesm6_gpio.
// Down-counts prescaled ticks, sets a sticky expiry flag, optionally reloads,
// and drives a level interrupt into the PIC irq vector.
// PARAMETERS
// PRESCALE  10  clk cycles per timer tick (>=1; 10 => 1 us at 10 MHz clk)
// CNT_W     32  counter/reload width (1..48); reads zero-extend, writes truncate
// PORTS
// clk      in   1   clock, rising edge
// reset    in   1   synchronous, active-high reset
// o_int    out  1   interrupt request, level: STATUS.expired & CTRL.irq_en
// i_addr   in   15  word address; only [1:0] decoded, upper bits ignored
// i_read   in   1   read request, held by initiator until o_done seen
// i_write  in   1   write request, held by initiator until o_done seen
// i_wdata  in   48  write data, stable while i_write high
// o_rdata  out  48  read data, valid only in the o_done cycle, else 0
// o_done   out  1   one-cycle completion pulse
// BEHAVIOUR
// Reset: state IDLE; CTRL, RELOAD, COUNT, STATUS, prescaler = 0;
//   o_done = 0, o_rdata = 0, o_int = 0. Reset mid-transaction aborts it; a
//   request still held after reset is serviced as new.
// Registers (i_addr[1:0]):
//   0 CTRL   bit0 enable, bit1 auto_reload, bit2 irq_en; other bits read 0
//   1 RELOAD reload value
//   2 COUNT  read current count; write loads count directly
//   3 STATUS bit0 expired (sticky); write with wdata[0]=1 clears, 0 no effect
// Bus FSM:
//   IDLE: i_read|i_write high -> ACK; the write is committed, or the read
//     snapshot captured, on this edge.
//   ACK:  o_done=1 for exactly one cycle, o_rdata=snapshot -> WAIT.
//   WAIT: stay until i_read=0 and i_write=0 -> IDLE. A held request is not
//     re-serviced, so one request = one access.
//   Latency: o_done is high in the cycle after the request is first sampled.
//   i_read & i_write both high: treated as a write; o_rdata=0.
// Prescaler:
//   Counts 0..PRESCALE-1 while CTRL.enable=1; tick on the cycle it equals
//     PRESCALE-1, then wraps to 0.
//   Held at 0 while disabled; cleared by any CTRL write. PRESCALE=1 => tick
//     every cycle.
// Counter, on tick:
//   COUNT!=0: COUNT-1.
//   COUNT==0: expired<=1; if auto_reload then COUNT<=RELOAD, else
//     CTRL.enable<=0 and COUNT stays 0.
//   Period with auto_reload = (RELOAD+1) ticks. RELOAD=0 => expiry every tick.
// Simultaneous events:
//   bus write to COUNT and tick in the same cycle: the bus write wins, tick ignored.
//   STATUS clear and expiry in the same cycle: expiry wins, flag stays 1.
//   CTRL write that clears enable on an expiring tick: the CTRL write wins
//     (enable=0); expired is still set.
// o_int is combinational from registered STATUS/CTRL and has no added latency.
// TESTING
// 1 reset with i_read held on addr 2 -> after reset falls, single o_done,
//   o_rdata=0; no second o_done while i_read stays high.
// 2 PRESCALE=10; write COUNT=3, CTRL=0b101 -> expired and o_int rise exactly
//   40 clk after the CTRL ack; enable then reads 0; COUNT reads 0.
// 3 RELOAD=4, COUNT=0, CTRL=0b111 -> expiry every 50 clk (PRESCALE=10);
//   write STATUS=1 between expiries drops o_int; it re-rises at the next expiry.
// 4 STATUS clear timed on the expiring tick -> STATUS reads 1, o_int stays 1.
// 5 COUNT write of 0x7 on a tick cycle -> next read of COUNT = 7, not 6;
//   CNT_W=32 write 0xFFFF_1234_5678 -> reads 0x0000_1234_5678.
// 6 i_read & i_write both high on addr 1, wdata=9 -> o_rdata=0 in the ack
//   cycle; RELOAD reads 9 afterwards.

Source files
------------

// File: rtl/mesm6_timer.sv
// rtl/mesm6_timer.sv - interval timer responder on the mesm6 data bus
//
// Purpose: down-counts prescaled ticks, sets a sticky expiry flag, optionally
// reloads, and raises a level interrupt. Registers are reached through the
// rd/wr/addr/done bus handshake; one held request produces exactly one access.
//
// Ports:
//   clk      in   1   clock, rising edge
//   reset    in   1   synchronous, active-high reset
//   o_int    out  1   level interrupt = STATUS.expired & CTRL.irq_en
//   i_addr   in   15  word address, only [1:0] decoded
//   i_read   in   1   read request, held until o_done
//   i_write  in   1   write request, held until o_done
//   i_wdata  in   48  write data
//   o_rdata  out  48  read data, valid in the o_done cycle, else 0
//   o_done   out  1   one-cycle completion pulse
//
// Register map (i_addr[1:0]):
//   0 CTRL   bit0 enable, bit1 auto_reload, bit2 irq_en
//   1 RELOAD reload value
//   2 COUNT  current count (write loads directly)
//   3 STATUS bit0 expired, write 1 to clear

module mesm6_timer #(
    parameter int PRESCALE = 10,
    parameter int CNT_W    = 32
) (
    input  logic        clk,
    input  logic        reset,
    output logic        o_int,
    input  logic [14:0] i_addr,
    input  logic        i_read,
    input  logic        i_write,
    input  logic [47:0] i_wdata,
    output logic [47:0] o_rdata,
    output logic        o_done
);

    localparam int              PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACK,
        S_WAIT
    } state_t;

    state_t           state_q;
    logic             done_q;
    logic [47:0]      rdata_q;

    logic [2:0]       ctrl_q,    ctrl_d;
    logic [CNT_W-1:0] reload_q,  reload_d;
    logic [CNT_W-1:0] count_q,   count_d;
    logic             expired_q, expired_d;
    logic [PS_W-1:0]  presc_q,   presc_d;

    logic             wr_en;
    logic             wr_ctrl;
    logic             wr_reload;
    logic             wr_count;
    logic             wr_status;
    logic             tick;
    logic [47:0]      rd_mux;

    // Upper address bits and unused data bits are intentionally ignored.
    logic             unused_bits;
    assign unused_bits = ^{i_addr[14:2], i_wdata};

    // A write (including a simultaneous read+write) commits only on the edge
    // where IDLE first sees the request.
    assign wr_en     = (state_q == S_IDLE) && i_write;
    assign wr_ctrl   = wr_en && (i_addr[1:0] == 2'd0);
    assign wr_reload = wr_en && (i_addr[1:0] == 2'd1);
    assign wr_count  = wr_en && (i_addr[1:0] == 2'd2);
    assign wr_status = wr_en && (i_addr[1:0] == 2'd3);

    assign tick  = ctrl_q[0] && (presc_q == PS_MAX);
    assign o_int = expired_q & ctrl_q[2];

    always_comb begin
        rd_mux = '0;
        case (i_addr[1:0])
            2'd0:    rd_mux = {45'd0, ctrl_q};
            2'd1:    rd_mux = 48'(reload_q);
            2'd2:    rd_mux = 48'(count_q);
            default: rd_mux = {47'd0, expired_q};
        endcase
    end

    // Ordering inside this block encodes the collision priorities:
    // STATUS clear is applied before expiry so expiry wins; CTRL/COUNT
    // writes are applied after the tick so the bus write wins.
    always_comb begin
        ctrl_d    = ctrl_q;
        reload_d  = reload_q;
        count_d   = count_q;
        expired_d = expired_q;
        presc_d   = presc_q;

        if (!ctrl_q[0] || tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PS_W'(1);
        end

        if (wr_status && i_wdata[0]) begin
            expired_d = 1'b0;
        end

        if (tick) begin
            if (count_q != '0) begin
                count_d = count_q - CNT_W'(1);
            end else begin
                expired_d = 1'b1;
                if (ctrl_q[1]) begin
                    count_d = reload_q;
                end else begin
                    ctrl_d[0] = 1'b0;
                end
            end
        end

        if (wr_ctrl) begin
            ctrl_d  = i_wdata[2:0];
            presc_d = '0;
        end
        if (wr_reload) begin
            reload_d = i_wdata[CNT_W-1:0];
        end
        if (wr_count) begin
            count_d = i_wdata[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q    <= '0;
            reload_q  <= '0;
            count_q   <= '0;
            expired_q <= 1'b0;
            presc_q   <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            reload_q  <= reload_d;
            count_q   <= count_d;
            expired_q <= expired_d;
            presc_q   <= presc_d;
        end
    end

    // Bus handshake: IDLE -> ACK (done pulse) -> WAIT until request drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q  <= 1'b0;
                    rdata_q <= '0;
                    if (i_read || i_write) begin
                        state_q <= S_ACK;
                        done_q  <= 1'b1;
                        rdata_q <= i_write ? 48'd0 : rd_mux;
                    end
                end
                S_ACK: begin
                    done_q  <= 1'b0;
                    rdata_q <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    done_q  <= 1'b0;
                    rdata_q <= '0;
                    if (!i_read && !i_write) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    done_q  <= 1'b0;
                    rdata_q <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_done  = done_q;
    assign o_rdata = rdata_q;

endmodule

// File: tb/tb_mesm6_timer.sv
// tb/tb_mesm6_timer.sv - directed self-checking bench for mesm6_timer

module tb_mesm6_timer;

    logic        clk;
    logic        reset;
    logic        o_int;
    logic [14:0] i_addr;
    logic        i_read;
    logic        i_write;
    logic [47:0] i_wdata;
    logic [47:0] o_rdata;
    logic        o_done;

    int checks;
    int failures;
    int cyc;
    int last_ack;
    int t1;
    int t2;
    int t3;

    mesm6_timer #(
        .PRESCALE(10),
        .CNT_W   (32)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .o_int  (o_int),
        .i_addr (i_addr),
        .i_read (i_read),
        .i_write(i_write),
        .i_wdata(i_wdata),
        .o_rdata(o_rdata),
        .o_done (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // One bus access: drive at a negedge, wait for o_done, then drop the
    // request and idle one more negedge so the responder returns to IDLE.
    task automatic bus(input logic wr, input logic rd, input logic [1:0] addr,
                       input logic [47:0] wd, output logic [47:0] rdat);
        bit got;
        got  = 0;
        rdat = '0;
        @(negedge clk);
        i_write = wr;
        i_read  = rd;
        i_addr  = {13'd0, addr};
        i_wdata = wd;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (o_done) begin
                got      = 1;
                rdat     = o_rdata;
                last_ack = cyc;
                break;
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL bus_timeout addr=%0d got=no_done exp=done", addr);
        end
        i_write = 1'b0;
        i_read  = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_int(output int t, output bit ok);
        ok = 0;
        t  = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (o_int) begin
                ok = 1;
                t  = cyc;
                break;
            end
        end
    endtask

    task automatic wait_cyc(input int target);
        for (int k = 0; k < 500 && cyc < target; k++) begin
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [47:0] r;
        int          pulses;
        logic [47:0] cap;
        reset   = 1'b1;
        i_read  = 1'b1;
        i_write = 1'b0;
        i_addr  = 15'd2;
        i_wdata = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (o_done !== 1'b0 || o_rdata !== 48'd0 || o_int !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b/%0h/%b exp=0/0/0", o_done, o_rdata, o_int);
        end
        reset  = 1'b0;
        pulses = 0;
        cap    = 48'hDEAD;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (o_done) begin
                pulses++;
                cap = o_rdata;
            end
        end
        checks++;
        if (pulses !== 1) begin
            failures++;
            $display("FAIL reset_held_read_pulses got=%0d exp=1", pulses);
        end
        checks++;
        if (cap !== 48'd0) begin
            failures++;
            $display("FAIL reset_held_read_data got=%0h exp=0", cap);
        end
        i_read = 1'b0;
        repeat (2) @(negedge clk);
        bus(1'b0, 1'b1, 2'd0, '0, r);
        checks++;
        if (r !== 48'd0) begin
            failures++;
            $display("FAIL reset_ctrl got=%0h exp=0", r);
        end
        bus(1'b0, 1'b1, 2'd3, '0, r);
        checks++;
        if (r !== 48'd0) begin
            failures++;
            $display("FAIL reset_status got=%0h exp=0", r);
        end
    endtask

    task automatic test_oneshot();
        logic [47:0] r;
        bus(1'b1, 1'b0, 2'd2, 48'd3, r);
        bus(1'b1, 1'b0, 2'd0, 48'd5, r);
        // Now at the negedge after ack edge + 1; expiry edge is ack + 40.
        repeat (38) @(negedge clk);
        checks++;
        if (o_int !== 1'b0) begin
            failures++;
            $display("FAIL oneshot_early got=%b exp=0", o_int);
        end
        @(negedge clk);
        checks++;
        if (o_int !== 1'b1) begin
            failures++;
            $display("FAIL oneshot_at40 got=%b exp=1", o_int);
        end
        bus(1'b0, 1'b1, 2'd0, '0, r);
        checks++;
        if (r !== 48'd4) begin
            failures++;
            $display("FAIL oneshot_ctrl got=%0h exp=4", r);
        end
        bus(1'b0, 1'b1, 2'd2, '0, r);
        checks++;
        if (r !== 48'd0) begin
            failures++;
            $display("FAIL oneshot_count got=%0h exp=0", r);
        end
        bus(1'b1, 1'b0, 2'd3, 48'd0, r);
        checks++;
        if (o_int !== 1'b1) begin
            failures++;
            $display("FAIL status_write0_keeps got=%b exp=1", o_int);
        end
        bus(1'b1, 1'b0, 2'd3, 48'd1, r);
        checks++;
        if (o_int !== 1'b0) begin
            failures++;
            $display("FAIL oneshot_clear got=%b exp=0", o_int);
        end
    endtask

    task automatic test_autoreload();
        logic [47:0] r;
        bit          ok;
        int          ack;
        bus(1'b1, 1'b0, 2'd1, 48'd4, r);
        bus(1'b1, 1'b0, 2'd2, 48'd0, r);
        bus(1'b1, 1'b0, 2'd0, 48'd7, r);
        ack = last_ack;
        wait_int(t1, ok);
        checks++;
        if (!ok || (t1 - ack) !== 10) begin
            failures++;
            $display("FAIL auto_first_expiry got=%0d exp=10", t1 - ack);
        end
        bus(1'b1, 1'b0, 2'd3, 48'd1, r);
        checks++;
        if (o_int !== 1'b0) begin
            failures++;
            $display("FAIL auto_clear got=%b exp=0", o_int);
        end
        wait_int(t2, ok);
        checks++;
        if (!ok || (t2 - t1) !== 50) begin
            failures++;
            $display("FAIL auto_period got=%0d exp=50", t2 - t1);
        end
    endtask

    task automatic test_clear_collision();
        logic [47:0] r;
        t3 = t2 + 50;
        wait_cyc(t3 - 2);
        bus(1'b1, 1'b0, 2'd3, 48'd1, r);
        checks++;
        if (last_ack !== t3) begin
            failures++;
            $display("FAIL collide_align got=%0d exp=%0d", last_ack, t3);
        end
        checks++;
        if (o_int !== 1'b1) begin
            failures++;
            $display("FAIL collide_int got=%b exp=1", o_int);
        end
        bus(1'b0, 1'b1, 2'd3, '0, r);
        checks++;
        if (r !== 48'd1) begin
            failures++;
            $display("FAIL collide_status got=%0h exp=1", r);
        end
    endtask

    task automatic test_count_write();
        logic [47:0] r;
        int          w;
        w = t3 + 30;
        wait_cyc(w - 2);
        bus(1'b1, 1'b0, 2'd2, 48'd7, r);
        checks++;
        if (last_ack !== w) begin
            failures++;
            $display("FAIL cntwr_align got=%0d exp=%0d", last_ack, w);
        end
        bus(1'b0, 1'b1, 2'd2, '0, r);
        checks++;
        if (r !== 48'd7) begin
            failures++;
            $display("FAIL cntwr_on_tick got=%0h exp=7", r);
        end
        bus(1'b1, 1'b0, 2'd0, 48'd0, r);
        bus(1'b1, 1'b0, 2'd2, 48'hFFFF_1234_5678, r);
        bus(1'b0, 1'b1, 2'd2, '0, r);
        checks++;
        if (r !== 48'h0000_1234_5678) begin
            failures++;
            $display("FAIL cnt_truncate got=%0h exp=12345678", r);
        end
        bus(1'b1, 1'b0, 2'd0, 48'hFFF8, r);
        bus(1'b0, 1'b1, 2'd0, '0, r);
        checks++;
        if (r !== 48'd0) begin
            failures++;
            $display("FAIL ctrl_upper_bits got=%0h exp=0", r);
        end
    endtask

    task automatic test_rw_conflict();
        logic [47:0] r;
        bus(1'b1, 1'b1, 2'd1, 48'd9, r);
        checks++;
        if (r !== 48'd0) begin
            failures++;
            $display("FAIL rw_rdata got=%0h exp=0", r);
        end
        bus(1'b0, 1'b1, 2'd1, '0, r);
        checks++;
        if (r !== 48'd9) begin
            failures++;
            $display("FAIL rw_reload got=%0h exp=9", r);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        last_ack = 0;
        t1 = 0;
        t2 = 0;
        t3 = 0;
        test_reset();
        test_oneshot();
        test_autoreload();
        test_clear_collision();
        test_count_write();
        test_rw_conflict();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
